// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - ALU executor with handshake; iterative shifter, or single-cycle shifts
// when ALU_SEQ_BARREL_SHIFT_EN is defined.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   calc;
  logic               legal;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

  // Single-cycle datapath; without the barrel option a shift reaching here has shamt==0.
  always_comb begin
    calc  = '0;
    legal = 1'b1;
    case (alu_op)
      OP_AND:  calc = op_a & op_b;
      OP_OR:   calc = op_a | op_b;
      OP_ADD:  calc = op_a + op_b;
      OP_XOR:  calc = op_a ^ op_b;
      OP_SUB:  calc = op_a - op_b;
      OP_SLT:  calc = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: calc = {{(WIDTH-1){1'b0}}, op_a < op_b};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      OP_SLL:  calc = op_a << shamt;
      OP_SRL:  calc = op_a >> shamt;
      OP_SRA:  calc = $signed(op_a) >>> shamt;
`else
      OP_SLL, OP_SRL, OP_SRA: calc = op_a;
`endif
      default: legal = 1'b0;
    endcase
  end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   step;

  always_comb begin
    step = result_q;
    case (op_q)
      OP_SLL:  step = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: step = result_q;
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    op_d  = op_q;
    cnt_d = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          illegal_d = ~legal;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
          result_d = calc;
          state_d  = S_DONE;
`else
          op_d = alu_op;
          if ((alu_op == OP_SLL || alu_op == OP_SRL || alu_op == OP_SRA) && shamt != '0) begin
            result_d = op_a;
            cnt_d    = shamt;
            state_d  = S_SHIFT;
          end else begin
            result_d = calc;
            state_d  = S_DONE;
          end
`endif
        end
      end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      S_SHIFT: begin
        result_d = step;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      op_q      <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      op_q      <= op_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign result     = result_q;
  assign zero       = (result_q == '0);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - randomized and directed bench for alu_seq_exec against a behavioural model
module tb_alu_seq_exec;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, zero, illegal_op;
  logic [3:0]   alu_op;
  logic [W-1:0] op_a, op_b, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = a ^ b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1011: r = (a < b) ? 1 : 0;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      4'b1010: r = $signed(a) >>> sh;
      default: begin r = '0; ill = 1'b1; end
    endcase
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && sh > 0) lat = sh + 1;
`endif
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic         eill;
    int           elat, lat, n;
    model(op, a, b, er, eill, elat);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("in_ready_before_accept", in_ready, 1);
    alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check($sformatf("latency op=%b", op), lat, elat);
    check($sformatf("result op=%b", op), result, er);
    check($sformatf("zero op=%b", op), zero, (er == '0));
    check($sformatf("illegal op=%b", op), illegal_op, eill);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_result", result, er);
      check("hold_zero", zero, (er == '0));
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_zero", zero, 1);
    check("reset_illegal", illegal_op, 0);
    rst = 1'b0;

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(4'b0110, 32'd5, 32'd5, 0);
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'b1011, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(4'b1010, 32'h8000_0000, 32'd31, 0);
    run_op(4'b1001, 32'h8000_0000, 32'd31, 0);
    run_op(4'b1000, 32'h1, 32'h0, 0);
    run_op(4'b1000, 32'h1, 32'h25, 0);
    run_op(4'b0001, 32'h1234_0000, 32'h0000_5678, 10);
    run_op(4'b0100, 32'hDEAD_BEEF, 32'h1, 2);
    run_op(4'b0011, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0);

    // Reset arriving while a long shift is in flight must leave no result behind.
    @(negedge clk);
    alu_op = 4'b1000; op_a = 32'h0000_0003; op_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midshift_rst_in_ready", in_ready, 1);
    check("midshift_rst_out_valid", out_valid, 0);
    check("midshift_rst_result", result, 0);
    check("midshift_rst_zero", zero, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("midshift_no_stale_result", seen, 0);
    end

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b[4:0] = 5'd0;
        1: b[4:0] = 5'd31;
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) b = a;
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
